paicore_recv_ctrl: RTL and testbench
====================================

Name: paicore_recv_ctrl

Overview:
Session controller for the PAICORE receive path (req/ack receiver -> transport_up -> data padding -> AXIS FIFO). It opens a receive window on a host start command and counts chip-side frames (snn_out_hsked) and host-side frames (read_hsked). It closes the window once the chip has gone quiet, waits for the transport flush and for padding to reach the configured frame count, then signals completion. It drives i_rx_rcving, i_recv_busy and i_recv_done of the receive path.

Parameters:
CNT_W, 32, width of frame counters and of the config registers
IDLE_W, 32, width of the idle/watchdog counter

Ports:
clk  in  1  single clock for the whole receive path
rst  in  1  asynchronous, active-high reset
i_start  in  1  one-cycle start pulse from the host register block
i_abort  in  1  one-cycle abort pulse from the host register block
i_frame_num_max  in  CNT_W  expected output frame count (same value fed to padding oFrameNumMax)
i_timeout  in  IDLE_W  idle/watchdog limit in cycles; 0 is treated as 1
i_chip_busy  in  1  PAICORE compute-busy indication
i_snn_out_hsked  in  1  frame accepted from chip (transport_up handshake)
i_read_hsked  in  1  frame written toward the FIFO (padding handshake)
i_rx_done  in  1  transport_up flush complete (o_rx_done of the path)
o_rx_rcving  out  1  receive window open
o_recv_busy  out  1  session active
o_recv_done  out  1  chip output finished; request transport flush
o_done  out  1  one-cycle session-complete pulse
o_err  out  1  sticky error: drain watchdog expiry or write overflow; cleared on next i_start
o_rx_cnt  out  CNT_W  frames received from chip this session
o_wr_cnt  out  CNT_W  frames written out this session

Behaviour:
- Reset: state IDLE, every output 0, all counters 0.
- FSM states: IDLE, RECV, FLUSH, DRAIN, DONE. All outputs are registered.
- IDLE:
  - i_start: clear o_rx_cnt, o_wr_cnt, the idle counter and o_err; go to RECV on the next edge.
  - i_start is ignored in every other state.
- RECV:
  - o_rx_rcving=1, o_recv_busy=1.
  - The idle counter clears on any cycle with i_chip_busy or i_snn_out_hsked; otherwise it increments.
  - When the idle counter reaches max(i_timeout,1), go to FLUSH and clear the idle counter.
- FLUSH:
  - o_recv_done=1 (level), o_recv_busy=1, o_rx_rcving=1.
  - Wait for i_rx_done. If i_rx_done is already high on entry, leave after one cycle.
  - Then go to DRAIN. The idle counter keeps running as a watchdog.
- DRAIN:
  - o_recv_busy=1; o_rx_rcving=0; o_recv_done=0.
  - Go to DONE when o_wr_cnt == i_frame_num_max, including the cycle whose i_read_hsked makes it equal.
  - Watchdog: the idle counter runs in FLUSH and DRAIN and clears on each i_read_hsked. When it reaches max(i_timeout,1), set o_err and go to DONE.
- DONE: o_done=1 for exactly one cycle, o_recv_busy=0, then IDLE. The counters hold their values until the next start.
- Counters:
  - o_rx_cnt increments on i_snn_out_hsked in any non-IDLE state.
  - o_wr_cnt increments on i_read_hsked in any non-IDLE state.
  - Both saturate at all-ones. An increment of o_wr_cnt beyond i_frame_num_max sets o_err.
  - Handshakes in IDLE are not counted.
- Abort: i_abort in any non-IDLE state forces IDLE on the next edge. All outputs drop to 0 except the counters and o_err, and o_done is not pulsed. Abort wins over any same-cycle transition or start.
- i_frame_num_max == 0: DRAIN exits on entry.
- Config inputs are sampled continuously; the host holds them stable while o_recv_busy.
- Reset mid-session: immediate return to the reset state; downstream sees i_rx_rcving fall asynchronously.

Decomposition:
- Shared package paicore_pkg: state encoding typedef (IDLE=0, RECV=1, FLUSH=2, DRAIN=3, DONE=4) and default CNT_W/IDLE_W constants.
- One sub-module, paicore_idle_timer: clearable, saturating idle counter with an expiry compare against max(limit,1). It is instantiated once and reused as both the RECV quiet detector and the FLUSH/DRAIN watchdog.

Test Plan:
- Nominal session:
  - Stimulus: i_timeout=16, i_frame_num_max=8; start; chip busy 20 cycles with 5 snn_out_hsked; chip idle; i_rx_done 3 cycles after o_recv_done rises; 8 read_hsked.
  - Response: o_recv_done rises 16 cycles after the last busy cycle; o_rx_cnt=5, o_wr_cnt=8; o_done single pulse; o_err=0.
- Quiet detector restart: a snn_out_hsked at idle count 15 (i_timeout=16) restarts the count -> FLUSH entered exactly 16 cycles after that handshake.
- Drain watchdog: i_frame_num_max=8, only 6 read_hsked then silence, i_timeout=10 -> o_err=1 and o_done pulse 10 cycles after the 6th handshake; o_wr_cnt=6.
- Abort: i_abort in DRAIN on the same cycle as the completing read_hsked -> IDLE next cycle, no o_done, all control outputs 0; the next i_start clears o_err and the counters.
- Edge cases:
  - i_timeout=0 behaves as 1.
  - i_frame_num_max=0: DONE directly after FLUSH.
  - i_start while RECV is ignored.
  - A 9th read_hsked with max=8 sets o_err.
- Async reset asserted mid-RECV -> all outputs 0 immediately, state IDLE; a start after release runs a clean session.

Source files
------------

// File: rtl/paicore_pkg.sv
// Shared types and defaults for the PAICORE receive-path session controller.
package paicore_pkg;

  localparam int CNT_W_DEF  = 32;
  localparam int IDLE_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/paicore_idle_timer.sv
// Clearable, saturating idle counter; expired flags the cycle whose increment
// would reach max(limit,1), so the caller can act on that same edge.
module paicore_idle_timer #(
  parameter int IDLE_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              kick,
  input  logic              clr,
  input  logic [IDLE_W-1:0] limit,
  output logic              expired
);

  localparam logic [IDLE_W-1:0] ONE = IDLE_W'(1);

  logic [IDLE_W-1:0] cnt;
  logic [IDLE_W-1:0] lim_eff;
  logic [IDLE_W-1:0] lim_m1;

  assign lim_eff = (limit == '0) ? ONE : limit;
  assign lim_m1  = lim_eff - ONE;
  assign expired = en && !kick && (cnt >= lim_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || kick) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/paicore_recv_ctrl.sv
// Receive-session controller: opens the window on start, closes it once the chip
// goes quiet, waits for transport flush and padding drain, then pulses o_done.
module paicore_recv_ctrl
  import paicore_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int IDLE_W = IDLE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [CNT_W-1:0]  i_frame_num_max,
  input  logic [IDLE_W-1:0] i_timeout,
  input  logic              i_chip_busy,
  input  logic              i_snn_out_hsked,
  input  logic              i_read_hsked,
  input  logic              i_rx_done,
  output logic              o_rx_rcving,
  output logic              o_recv_busy,
  output logic              o_recv_done,
  output logic              o_done,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_rx_cnt,
  output logic [CNT_W-1:0]  o_wr_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nx;
  logic             active;
  logic             snn_cnt, rd_cnt, wr_ovf;
  logic [CNT_W-1:0] wr_nx;
  logic             tmr_en, tmr_kick, tmr_clr, tmr_exp;
  logic             wd_err;

  assign active  = (state != ST_IDLE);
  assign snn_cnt = active && i_snn_out_hsked;
  assign rd_cnt  = active && i_read_hsked;
  assign wr_nx   = (rd_cnt && (o_wr_cnt != '1)) ? o_wr_cnt + CNT_ONE : o_wr_cnt;
  assign wr_ovf  = rd_cnt && (o_wr_cnt >= i_frame_num_max);

  // One timer serves as the RECV quiet detector and the FLUSH/DRAIN watchdog
  assign tmr_en   = (state == ST_RECV) || (state == ST_FLUSH) || (state == ST_DRAIN);
  assign tmr_kick = (state == ST_RECV) ? (i_chip_busy || i_snn_out_hsked) : i_read_hsked;
  assign tmr_clr  = !tmr_en || ((state == ST_RECV) && tmr_exp);

  paicore_idle_timer #(.IDLE_W(IDLE_W)) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (tmr_en),
    .kick    (tmr_kick),
    .clr     (tmr_clr),
    .limit   (i_timeout),
    .expired (tmr_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wd_err   = 1'b0;
    case (state)
      ST_IDLE:  if (i_start) state_nx = ST_RECV;
      ST_RECV:  if (tmr_exp) state_nx = ST_FLUSH;
      ST_FLUSH: begin
        if (i_rx_done) begin
          state_nx = ST_DRAIN;
        end else if (tmr_exp) begin
          state_nx = ST_DONE;
          wd_err   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (wr_nx == i_frame_num_max) begin
          state_nx = ST_DONE;
        end else if (tmr_exp) begin
          state_nx = ST_DONE;
          wd_err   = 1'b1;
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    // Abort overrides every other transition out of an active state
    if (i_abort && active) begin
      state_nx = ST_IDLE;
      wd_err   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rx_rcving <= 1'b0;
      o_recv_busy <= 1'b0;
      o_recv_done <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_rx_rcving <= (state_nx == ST_RECV) || (state_nx == ST_FLUSH);
      o_recv_busy <= (state_nx == ST_RECV) || (state_nx == ST_FLUSH) || (state_nx == ST_DRAIN);
      o_recv_done <= (state_nx == ST_FLUSH);
      o_done      <= (state_nx == ST_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rx_cnt <= '0;
      o_wr_cnt <= '0;
      o_err    <= 1'b0;
    end else if ((state == ST_IDLE) && i_start) begin
      o_rx_cnt <= '0;
      o_wr_cnt <= '0;
      o_err    <= 1'b0;
    end else begin
      if (snn_cnt && (o_rx_cnt != '1)) o_rx_cnt <= o_rx_cnt + CNT_ONE;
      o_wr_cnt <= wr_nx;
      if (wr_ovf || wd_err) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_paicore_recv_ctrl.sv
// Bench for paicore_recv_ctrl: vector table, directed corner sequences and
// randomized traffic checked cycle by cycle against a behavioural session model.
module tb_paicore_recv_ctrl;

  localparam int CNT_W  = 32;
  localparam int IDLE_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_start = 0, i_abort = 0;
  logic [CNT_W-1:0]  i_frame_num_max = '0;
  logic [IDLE_W-1:0] i_timeout = '0;
  logic              i_chip_busy = 0, i_snn_out_hsked = 0, i_read_hsked = 0, i_rx_done = 0;
  logic              o_rx_rcving, o_recv_busy, o_recv_done, o_done, o_err;
  logic [CNT_W-1:0]  o_rx_cnt, o_wr_cnt;

  always #5 clk = ~clk;

  paicore_recv_ctrl #(.CNT_W(CNT_W), .IDLE_W(IDLE_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .i_abort         (i_abort),
    .i_frame_num_max (i_frame_num_max),
    .i_timeout       (i_timeout),
    .i_chip_busy     (i_chip_busy),
    .i_snn_out_hsked (i_snn_out_hsked),
    .i_read_hsked    (i_read_hsked),
    .i_rx_done       (i_rx_done),
    .o_rx_rcving     (o_rx_rcving),
    .o_recv_busy     (o_recv_busy),
    .o_recv_done     (o_recv_done),
    .o_done          (o_done),
    .o_err           (o_err),
    .o_rx_cnt        (o_rx_cnt),
    .o_wr_cnt        (o_wr_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  // Behavioural session model: phase plus plain integer counters
  localparam int P_IDLE = 0, P_RECV = 1, P_FLUSH = 2, P_DRAIN = 3, P_DONE = 4;
  localparam longint SAT = 64'h0000_0000_FFFF_FFFF;
  int     m_ph;
  longint m_idle, m_rx, m_wr;
  bit     m_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_idle = 0; m_rx = 0; m_wr = 0; m_err = 0;
  endtask

  task automatic model_step();
    longint lim, fmax;
    bit     quiet_exp;
    lim  = (i_timeout == 0) ? 1 : longint'(i_timeout);
    fmax = longint'(i_frame_num_max);
    if (m_ph == P_IDLE) begin
      if (i_start) begin
        m_rx = 0; m_wr = 0; m_err = 0; m_idle = 0; m_ph = P_RECV;
      end
    end else begin
      if (i_snn_out_hsked && m_rx < SAT) m_rx++;
      if (i_read_hsked) begin
        if (m_wr >= fmax) m_err = 1;
        if (m_wr < SAT) m_wr++;
      end
      quiet_exp = !i_read_hsked && (m_idle + 1 >= lim);
      if (i_abort) begin
        m_ph = P_IDLE; m_idle = 0;
      end else begin
        case (m_ph)
          P_RECV: begin
            if (i_chip_busy || i_snn_out_hsked) m_idle = 0;
            else if (m_idle + 1 >= lim) begin m_ph = P_FLUSH; m_idle = 0; end
            else m_idle++;
          end
          P_FLUSH, P_DRAIN: begin
            if (m_ph == P_FLUSH && i_rx_done) m_ph = P_DRAIN;
            else if (m_ph == P_DRAIN && m_wr == fmax) m_ph = P_DONE;
            else if (quiet_exp) begin m_err = 1; m_ph = P_DONE; end
            m_idle = i_read_hsked ? 0 : m_idle + 1;
          end
          default: m_ph = P_IDLE;
        endcase
      end
    end
  endtask

  task automatic check_model();
    logic [3:0] exp_f;
    exp_f = {(m_ph == P_RECV || m_ph == P_FLUSH),
             (m_ph == P_RECV || m_ph == P_FLUSH || m_ph == P_DRAIN),
             (m_ph == P_FLUSH), (m_ph == P_DONE)};
    chk("model_ctrl", {o_rx_rcving, o_recv_busy, o_recv_done, o_done}, exp_f);
    chk("model_err", o_err, m_err);
    chk("model_cnt", {o_rx_cnt, o_wr_cnt}, {m_rx[31:0], m_wr[31:0]});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_model();
    i_start = 0;
    i_abort = 0;
  endtask

  task automatic wait_recv_done();
    int n = 0;
    while (!o_recv_done && n < 200) begin cyc(); n++; end
    chk("wait_recv_done", o_recv_done, 1'b1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!o_done && n < 200) begin cyc(); n++; end
    chk("wait_done", o_done, 1'b1);
  endtask

  typedef struct {
    logic       start, abort, busy, snn, rd, rxd;
    logic [4:0] exp_f;  // {rcving, busy, recv_done, done, err}
    int         exp_rx, exp_wr;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int n;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset_ctrl", {o_rx_rcving, o_recv_busy, o_recv_done, o_done, o_err}, 5'b0);
    chk("reset_cnt", {o_rx_cnt, o_wr_cnt}, 64'd0);

    // Short session with timeout=2, frame max=1, then start/abort/idle handshake
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, 0, 0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b11000, 1, 0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, 1, 0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11100, 1, 0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b01000, 1, 0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00010, 1, 1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 1, 1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, 0, 0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 0, 0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 0, 0};
    i_timeout = 2; i_frame_num_max = 1;
    for (int r = 0; r < 10; r++) begin
      i_start = tbl[r].start; i_abort = tbl[r].abort; i_chip_busy = tbl[r].busy;
      i_snn_out_hsked = tbl[r].snn; i_read_hsked = tbl[r].rd; i_rx_done = tbl[r].rxd;
      cyc();
      chk($sformatf("tbl%0d_flags", r), {o_rx_rcving, o_recv_busy, o_recv_done, o_done, o_err}, tbl[r].exp_f);
      chk($sformatf("tbl%0d_cnt", r), {o_rx_cnt, o_wr_cnt}, {32'(tbl[r].exp_rx), 32'(tbl[r].exp_wr)});
    end
    i_chip_busy = 0; i_snn_out_hsked = 0; i_read_hsked = 0; i_rx_done = 0;

    // Nominal session, including a start pulse ignored while receiving
    i_timeout = 16; i_frame_num_max = 8; i_start = 1; cyc();
    for (int i = 0; i < 20; i++) begin
      i_chip_busy = 1; i_snn_out_hsked = (i % 4 == 0);
      if (i == 10) i_start = 1;
      cyc();
      if (i == 10) chk("start_ignored", {o_rx_rcving, o_rx_cnt}, {1'b1, 32'd3});
    end
    i_chip_busy = 0; i_snn_out_hsked = 0;
    n = 0;
    while (!o_recv_done && n < 100) begin cyc(); n++; end
    chk("nominal_quiet_len", n, 16);
    cyc(); cyc();
    chk("nominal_flush_hold", o_recv_done, 1'b1);
    i_rx_done = 1; cyc(); i_rx_done = 0;
    i_read_hsked = 1; repeat (8) cyc(); i_read_hsked = 0;
    chk("nominal_done", {o_done, o_err, o_recv_busy}, 3'b100);
    chk("nominal_cnt", {o_rx_cnt, o_wr_cnt}, {32'd5, 32'd8});
    cyc();
    chk("nominal_done_pulse", o_done, 1'b0);

    // Quiet detector restarted by a handshake at idle count 15
    i_start = 1; cyc();
    i_chip_busy = 1; cyc(); i_chip_busy = 0;
    repeat (15) cyc();
    chk("restart_pre", o_recv_done, 1'b0);
    i_snn_out_hsked = 1; cyc(); i_snn_out_hsked = 0;
    n = 0;
    while (!o_recv_done && n < 100) begin cyc(); n++; end
    chk("restart_quiet_len", n, 16);
    i_abort = 1; cyc();

    // Drain watchdog: 6 of 8 frames, then silence
    i_timeout = 10; i_frame_num_max = 8; i_start = 1; cyc();
    wait_recv_done();
    i_rx_done = 1; cyc(); i_rx_done = 0;
    i_read_hsked = 1; repeat (6) cyc(); i_read_hsked = 0;
    n = 0;
    while (!o_done && n < 100) begin cyc(); n++; end
    chk("wd_len", n, 10);
    chk("wd_err", {o_err, o_wr_cnt}, {1'b1, 32'd6});
    cyc();

    // Abort on the completing read in DRAIN; next start clears state
    i_timeout = 4; i_frame_num_max = 2; i_start = 1; cyc();
    chk("start_clears_err", o_err, 1'b0);
    wait_recv_done();
    i_rx_done = 1; cyc(); i_rx_done = 0;
    i_read_hsked = 1; cyc();
    i_abort = 1; cyc(); i_read_hsked = 0;
    chk("abort_ctrl", {o_rx_rcving, o_recv_busy, o_recv_done, o_done}, 4'b0);
    cyc();
    chk("abort_no_done", o_done, 1'b0);
    i_start = 1; cyc();
    chk("abort_restart", {o_err, o_rx_cnt, o_wr_cnt}, 65'd0);
    i_abort = 1; cyc();

    // Timeout 0 acts as 1; frame max 0 leaves DRAIN at once
    i_timeout = 0; i_frame_num_max = 0; i_start = 1; cyc();
    cyc();
    chk("tmo0_flush", o_recv_done, 1'b1);
    i_rx_done = 1; cyc(); i_rx_done = 0;
    chk("max0_drain", {o_rx_rcving, o_recv_busy}, 2'b01);
    cyc();
    chk("max0_done", o_done, 1'b1);
    cyc();

    // Ninth read with max 8 flags overflow
    i_timeout = 10; i_frame_num_max = 8; i_start = 1; cyc();
    wait_recv_done();
    i_read_hsked = 1; repeat (8) cyc();
    chk("ovf_pre", o_err, 1'b0);
    cyc(); i_read_hsked = 0;
    chk("ovf_err", {o_err, o_wr_cnt}, {1'b1, 32'd9});
    i_rx_done = 1; cyc(); i_rx_done = 0;
    wait_done();
    cyc();

    // Asynchronous reset mid-RECV, then a clean session
    i_timeout = 8; i_start = 1; cyc();
    i_chip_busy = 1; i_snn_out_hsked = 1; cyc(); cyc(); i_snn_out_hsked = 0;
    #3 rst = 1;
    #1;
    chk("areset_ctrl", {o_rx_rcving, o_recv_busy, o_recv_done, o_done, o_err}, 5'b0);
    chk("areset_cnt", {o_rx_cnt, o_wr_cnt}, 64'd0);
    model_reset();
    i_chip_busy = 0;
    @(posedge clk); #1 rst = 0;
    i_timeout = 3; i_frame_num_max = 1; i_start = 1; cyc();
    chk("post_reset_start", o_rx_rcving, 1'b1);
    wait_recv_done();
    i_rx_done = 1; cyc(); i_rx_done = 0;
    i_read_hsked = 1; cyc(); i_read_hsked = 0;
    chk("post_reset_done", {o_done, o_err, o_wr_cnt}, {2'b10, 32'd1});
    cyc();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (m_ph == P_IDLE) begin
        i_timeout = IDLE_W'($urandom_range(0, 6));
        i_frame_num_max = CNT_W'($urandom_range(0, 5));
        i_start = ($urandom_range(0, 3) == 0);
      end else begin
        i_start = ($urandom_range(0, 15) == 0);
      end
      i_abort = ($urandom_range(0, 63) == 0);
      i_chip_busy = ($urandom_range(0, 3) == 0);
      i_snn_out_hsked = ($urandom_range(0, 3) == 0);
      i_read_hsked = ($urandom_range(0, 2) == 0);
      i_rx_done = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
